logic_op_pipe: RTL and testbench



---
 rtl/logic_op_pipe.sv | 70 +++++++
 tb/tb_logic_op_pipe.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/logic_op_pipe.sv
// logic_op_pipe: handshaked bitwise logic unit with accumulator and stall-able output pipeline
module logic_op_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             parity
);
  logic [STAGES:1] v, z, p;
  logic [WIDTH-1:0] d [STAGES:1];
  logic [WIDTH-1:0] acc, x, w, f, r;
  logic advance, accept;
  assign advance   = !v[STAGES] || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign out_valid = v[STAGES];
  assign y         = d[STAGES];
  assign zero      = z[STAGES];
  assign parity    = p[STAGES];
  always_comb begin
    x = acc_en ? acc : a;
    w = acc_en ? a : b;
    case (op)
      3'd0:    f = x & w;
      3'd1:    f = x | w;
      3'd2:    f = x ^ w;
      3'd3:    f = ~(x & w);
      3'd4:    f = ~(x | w);
      3'd5:    f = ~(x ^ w);
      3'd6:    f = x;
      default: f = ~x;
    endcase
    r = (acc_en && acc_clr) ? a : f;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v   <= '0;
      z   <= '1;
      p   <= '0;
      d   <= '{default: '0};
      acc <= '0;
    end else if (advance) begin
      v[1] <= in_valid;
      if (in_valid) begin
        d[1] <= r;
        z[1] <= (r == '0);
        p[1] <= ^r;
        if (acc_en) acc <= r;
      end
      for (int i = 2; i <= STAGES; i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
        z[i] <= z[i-1];
        p[i] <= p[i-1];
      end
    end
  end
endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: scoreboard bench over STAGES=2, 1 and 4 instances of logic_op_pipe
module tb_logic_op_pipe;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic in_valid = 0, out_ready = 1, acc_en = 0, acc_clr = 0;
  logic [2:0] op = 0;
  logic [7:0] a = 0, b = 0;
  int sel = 0;
  logic ir_s [3], ov_s [3], z_s [3], p_s [3];
  logic [7:0] y_s [3];
  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gd
      logic_op_pipe #(.WIDTH(8), .STAGES(g == 0 ? 2 : (g == 1 ? 1 : 4))) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid && sel == g), .in_ready(ir_s[g]),
        .a(a), .b(b), .op(op), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(ov_s[g]), .out_ready(out_ready || sel != g),
        .y(y_s[g]), .zero(z_s[g]), .parity(p_s[g])
      );
    end
  endgenerate
  logic ir, ov, zf, pf;
  logic [7:0] yv;
  assign ir = ir_s[sel];
  assign ov = ov_s[sel];
  assign zf = z_s[sel];
  assign pf = p_s[sel];
  assign yv = y_s[sel];
  int tests = 0, fails = 0;
  logic [9:0] q[$];
  logic [7:0] basic_exp [8] = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'hF0, 8'h0F};
  logic [7:0] bp_a [5] = '{8'h01, 8'h07, 8'hFF, 8'h80, 8'h55};
  logic [7:0] bp_b [5] = '{8'h02, 8'h00, 8'h0F, 8'h00, 8'h54};
  logic [9:0] bp_exp [5] = '{{8'h03, 2'b00}, {8'h07, 2'b01}, {8'hF0, 2'b00}, {8'h80, 2'b01}, {8'h01, 2'b01}};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s (sel %0d): got %0h, expected %0h", name, sel, act, exp);
    end
  endtask
  function automatic logic [9:0] e(input logic [7:0] r);
    return {r, 2'b00};
  endfunction
  initial begin
    logic hold;
    logic [9:0] held;
    hold = 0;
    held = 0;
    forever begin
      @(negedge clk);
      if (hold) chk("stall_hold", {ov, yv, zf, pf}, {1'b1, held});
      hold = 0;
      if (!rst && ov && !out_ready) begin
        hold = 1;
        held = {yv, zf, pf};
        chk("stall_in_ready", ir, 0);
      end
      if (!rst && ov && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", {yv, zf, pf}, 10'h3FF);
        else chk("result", {yv, zf, pf}, q.pop_front());
      end
    end
  end
  task automatic send(input logic [2:0] o, input logic [7:0] x, w, input logic en, clr,
                      input logic [9:0] exp, input bit keep);
    op = o; a = x; b = w; acc_en = en; acc_clr = clr; in_valid = 1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ir && !rst) begin
        if (keep) q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 0;
        return;
      end
    end
    chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || ov) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask
  task automatic bp();
    fork
      for (int i = 0; i < 5; i++) send(3'd2, bp_a[i], bp_b[i], 0, 0, bp_exp[i], 1);
      begin
        int n;
        n = 0;
        while (!ov && n < 20) begin
          @(posedge clk); #1;
          n++;
        end
        chk("bp_first_valid", n < 20, 1);
        out_ready = 0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
  endtask
  task automatic lat(input int st);
    int n;
    send(3'd0, 8'hFF, 8'h81, 0, 0, e(8'h81), 1);
    n = 0;
    @(negedge clk);
    while (!ov && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, st - 1);
    drain();
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_out", {ov_s[k], y_s[k], z_s[k], p_s[k], ir_s[k]}, {1'b0, 8'h00, 1'b1, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) send(3'(i), 8'hF0, 8'h3C, 0, 0, e(basic_exp[i]), 1);
    send(3'd2, 8'hAA, 8'hAA, 0, 0, {8'h00, 1'b1, 1'b0}, 1);
    send(3'd2, 8'h01, 8'h00, 0, 0, {8'h01, 1'b0, 1'b1}, 1);
    drain();
    send(3'd0, 8'h0F, 8'h55, 1, 1, e(8'h0F), 1);
    send(3'd2, 8'hFF, 8'h55, 1, 0, e(8'hF0), 1);
    send(3'd0, 8'h3C, 8'h55, 1, 0, e(8'h30), 1);
    send(3'd6, 8'h00, 8'h00, 1, 0, e(8'h30), 1);
    send(3'd0, 8'hF0, 8'h3C, 0, 1, e(8'h30), 1);
    send(3'd6, 8'h00, 8'h00, 1, 0, e(8'h30), 1);
    drain();
    bp();
    out_ready = 0;
    send(3'd6, 8'h5A, 8'h00, 1, 1, 0, 0);
    send(3'd0, 8'hFF, 8'hFF, 0, 0, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    out_ready = 1;
    @(negedge clk);
    chk("rst_mid_valid", {ov, ir}, 2'b01);
    @(posedge clk); #1;
    send(3'd6, 8'h77, 8'h00, 1, 0, {8'h00, 1'b1, 1'b0}, 1);
    drain();
    lat(2);
    sel = 1;
    lat(1);
    bp();
    sel = 2;
    lat(4);
    bp();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
